// File: rtl/vic_pkg.sv
// Shared types and constants for the VIC interrupt-source block.
package vic_pkg;

  localparam int MAX_SRC    = 32;
  localparam int ISR_ADDR_W = $clog2(MAX_SRC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  // Index width for n sources; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// Circular priority encoder: first set bit of eligible at or after start, wrapping at N_SRC.
module vic_prio_enc
  import vic_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int IDX_W = idx_width(N_SRC)
) (
  input  logic [N_SRC-1:0] eligible,
  input  logic [IDX_W-1:0] start,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  always_comb begin : search
    int k;
    k      = 0;
    valid  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_SRC; i++) begin
      k = int'(start) + i;
      if (k >= N_SRC) k = k - N_SRC;
      if (!valid && eligible[k]) begin
        valid  = 1'b1;
        winner = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/vic_irq_src.sv
// VIC interrupt-source front end: edge capture, masking, prioritized non-nested grants.
// Define VIC_RR_PRIO_EN for round-robin priority; otherwise lowest index wins.
module vic_irq_src
  import vic_pkg::*;
#(
  parameter int N_SRC    = 8,
  parameter int VEC_BASE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      i_irq_src,
  input  logic [N_SRC-1:0]      i_irq_en,
  input  logic                  i_gie,
  input  logic                  i_reti,
  output logic                  o_IRQ,
  output logic [ISR_ADDR_W-1:0] o_ISR_addr,
  output logic [N_SRC-1:0]      o_pending,
  output logic                  o_busy
);

  localparam int IDX_W = idx_width(N_SRC);

  state_t                  state_reg;
  logic [N_SRC-1:0]        src_q_reg;
  logic [N_SRC-1:0]        pending_reg;
  logic                    irq_reg;
  logic                    busy_reg;
  logic [ISR_ADDR_W-1:0]   addr_reg;

  logic [N_SRC-1:0]        eligible;
  logic [N_SRC-1:0]        edge_det;
  logic [N_SRC-1:0]        clr_mask;
  logic [IDX_W-1:0]        start_ptr;
  logic                    enc_valid;
  logic [IDX_W-1:0]        winner;
  logic                    grant_ok;
  logic [ISR_ADDR_W-1:0]   vec_next;

  assign eligible = pending_reg & i_irq_en;
  assign edge_det = i_irq_src & ~src_q_reg;

  // A grant is only ever issued from IDLE or at the end-of-ISR pulse in SERVICE.
  assign grant_ok = i_gie & enc_valid &
                    ((state_reg == IDLE) | ((state_reg == SERVICE) & i_reti));

  assign vec_next = ISR_ADDR_W'(VEC_BASE) + ISR_ADDR_W'(winner);

  always_comb begin
    clr_mask = '0;
    if (grant_ok) clr_mask = N_SRC'(1) << winner;
  end

  vic_prio_enc #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_prio (
    .eligible (eligible),
    .start    (start_ptr),
    .valid    (enc_valid),
    .winner   (winner)
  );

`ifdef VIC_RR_PRIO_EN
  logic [IDX_W-1:0] rr_ptr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg <= '0;
    end else if (grant_ok) begin
      rr_ptr_reg <= (winner == IDX_W'(N_SRC - 1)) ? '0 : winner + 1'b1;
    end
  end

  assign start_ptr = rr_ptr_reg;
`else
  assign start_ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      src_q_reg   <= '0;
      pending_reg <= '0;
      irq_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      addr_reg    <= '0;
    end else begin
      src_q_reg   <= i_irq_src;
      // New edges are OR-ed in last so a re-trigger on the granted source survives.
      pending_reg <= (pending_reg & ~clr_mask) | edge_det;
      case (state_reg)
        IDLE: begin
          if (grant_ok) begin
            state_reg <= REQ;
            irq_reg   <= 1'b1;
            busy_reg  <= 1'b1;
            addr_reg  <= vec_next;
          end
        end
        REQ: begin
          state_reg <= SERVICE;
          irq_reg   <= 1'b0;
        end
        SERVICE: begin
          if (grant_ok) begin
            state_reg <= REQ;
            irq_reg   <= 1'b1;
            addr_reg  <= vec_next;
          end else if (i_reti) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          irq_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_IRQ      = irq_reg;
  assign o_busy     = busy_reg;
  assign o_ISR_addr = addr_reg;
  assign o_pending  = pending_reg;

endmodule

// File: tb/tb_vic_irq_src.sv
// Randomized and directed checks of vic_irq_src (VEC_BASE 0 and 30) against a behavioural model.
module tb_vic_irq_src;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] src;
  logic [N-1:0] en;
  logic         gie;
  logic         reti;

  logic         irq0, busy0, irq30, busy30;
  logic [4:0]   addr0, addr30;
  logic [N-1:0] pend0, pend30;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vic_irq_src #(.N_SRC(N), .VEC_BASE(0)) dut0 (
    .clk(clk), .rst(rst), .i_irq_src(src), .i_irq_en(en), .i_gie(gie), .i_reti(reti),
    .o_IRQ(irq0), .o_ISR_addr(addr0), .o_pending(pend0), .o_busy(busy0)
  );

  vic_irq_src #(.N_SRC(N), .VEC_BASE(30)) dut30 (
    .clk(clk), .rst(rst), .i_irq_src(src), .i_irq_en(en), .i_gie(gie), .i_reti(reti),
    .o_IRQ(irq30), .o_ISR_addr(addr30), .o_pending(pend30), .o_busy(busy30)
  );

  // Behavioural model: pending set, "request due" and "in service" flags, last granted index.
  logic [N-1:0] m_pend, m_prev;
  logic         m_irq, m_busy;
  int           m_last;
  logic [4:0]   m_addr0, m_addr30;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_irq = 0; m_busy = 0;
    m_last = N - 1; m_addr0 = 0; m_addr30 = 0;
  endtask

  function automatic int pick(input logic [N-1:0] el);
`ifdef VIC_RR_PRIO_EN
    for (int i = 1; i <= N; i++) begin
      int k = (m_last + i) % N;
      if (el[k]) return k;
    end
`else
    for (int i = 0; i < N; i++) if (el[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] edges, elig, nxt;
    int w;
    if (!rst) begin
      model_reset();
      return;
    end
    edges = src & ~m_prev;
    elig  = m_pend & en;
    nxt   = m_pend;
    if (m_irq) begin
      m_irq = 0;
    end else if ((!m_busy || reti) && gie && (elig != 0)) begin
      w = pick(elig);
      nxt[w]   = 1'b0;
      m_irq    = 1;
      m_busy   = 1;
      m_last   = w;
      m_addr0  = 5'((0 + w) % 32);
      m_addr30 = 5'((30 + w) % 32);
      $display("grant src=%0d vec0=%0d vec30=%0d t=%0t", w, m_addr0, m_addr30, $time);
    end else if (m_busy && reti) begin
      m_busy = 0;
    end
    m_pend = nxt | edges;
    m_prev = src;
  endtask

  task automatic compare_all();
    check("irq",     32'(irq0),   32'(m_irq));
    check("busy",    32'(busy0),  32'(m_busy));
    check("pending", 32'(pend0),  32'(m_pend));
    check("addr0",   32'(addr0),  32'(m_addr0));
    check("irq30",   32'(irq30),  32'(m_irq));
    check("addr30",  32'(addr30), 32'(m_addr30));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse(input logic [N-1:0] m);
    src = m;
    tick();
    src = '0;
  endtask

  task automatic do_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  task automatic wait_irq(input string tag);
    int cnt = 0;
    while (!irq0 && cnt < 12) begin
      tick();
      cnt++;
    end
    if (!irq0) check({tag, "_timeout"}, 32'(irq0), 32'd1);
  endtask

  logic [31:0] rnd;
  int          seq[$];
  bit          rst_done;

  initial begin
    rst = 1'b0; src = '0; en = '1; gie = 1'b1; reti = 1'b0;
    model_reset();
    tick();
    tick();
    #2 rst = 1'b1;
    tick();

    // single source 3: grant two edges after the sampled edge
    pulse(8'h08);
    check("t2_pend_first", 32'(pend0), 32'h08);
    check("t2_no_irq_yet", 32'(irq0), 32'd0);
    tick();
    check("t2_irq", 32'(irq0), 32'd1);
    check("t2_addr_base0", 32'(addr0), 32'd3);
    check("t2_addr_base30", 32'(addr30), 32'd1);
    tick();
    check("t2_irq_one_cycle", 32'(irq0), 32'd0);
    check("t2_busy", 32'(busy0), 32'd1);
    tick();
    do_reti();
    check("t2_idle", 32'(busy0), 32'd0);

    // simultaneous edges on 1 and 5, back-to-back grant on reti
    pulse(8'h22);
    tick();
    check("t3_addr_first", 32'(addr0), 32'd1);
    tick();
    do_reti();
    check("t3_b2b_irq", 32'(irq0), 32'd1);
    check("t3_addr_second", 32'(addr0), 32'd5);
    tick();
    do_reti();

    // masking then global enable
    en = 8'hFB;
    pulse(8'h04);
    tick(); tick();
    check("t4_masked_pend", 32'(pend0[2]), 32'd1);
    check("t4_masked_irq", 32'(irq0), 32'd0);
    en = '1;
    wait_irq("t4_unmask");
    check("t4_addr", 32'(addr0), 32'd2);
    tick();
    do_reti();
    gie = 1'b0;
    pulse(8'h04);
    tick(); tick(); tick();
    check("t4_gie_off", 32'(busy0), 32'd0);
    gie = 1'b1;
    wait_irq("t4_gie_on");
    tick();
    do_reti();

    // re-trigger of the source in service
    pulse(8'h10);
    wait_irq("t5_first");
    tick();
    pulse(8'h10);
    tick();
    check("t5_repend", 32'(pend0[4]), 32'd1);
    do_reti();
    check("t5_regrant", 32'(irq0), 32'd1);
    check("t5_addr", 32'(addr0), 32'd4);
    tick();
    do_reti();
    tick();

    // src0/src1 retriggered every service
    pulse(8'h03);
    for (int g = 0; g < 4; g++) begin
      wait_irq("t6_grant");
      seq.push_back(int'(addr0));
      tick();
      pulse(8'h03);
      tick();
      do_reti();
    end
    for (int g = 0; g < 4; g++) begin
`ifdef VIC_RR_PRIO_EN
      check("t6_rr_order", 32'(seq[g]), 32'(g % 2));
`else
      check("t6_fixed_order", 32'(seq[g]), 32'd0);
`endif
    end
    tick(); tick();

    // randomized traffic with one asynchronous reset while busy
    rst_done = 0;
    for (int i = 0; i < 1500; i++) begin
      rnd  = $urandom & $urandom & $urandom;
      src  = src ^ rnd[N-1:0];
      rnd  = $urandom & $urandom & $urandom;
      en   = ~rnd[N-1:0];
      gie  = ($urandom_range(0, 9) != 0);
      reti = ($urandom_range(0, 3) == 0);
      if (!rst_done && i >= 700 && busy0) begin
        rst_done = 1;
        #3 rst = 1'b0;
        #1;
        check("rst_async_irq", 32'(irq0), 32'd0);
        check("rst_async_busy", 32'(busy0), 32'd0);
        check("rst_async_pend", 32'(pend0), 32'd0);
        tick();
        rst = 1'b1;
      end
      tick();
    end
    if (!rst_done) check("rst_never_busy", 32'(rst_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
